// File: rtl/rv32i_mp_regfile.sv
// Multi-ported RV32I integer register file with a per-register scoreboard.
// x0 is hardwired to zero. When several write ports hit the same register, the highest port index wins.
module rv32i_mp_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        we_i,
   input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
   input  logic [NUM_WR*DATA_W-1:0] wdata_i,
   input  logic [NUM_RD-1:0]        re_i,
   input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
   output logic [NUM_RD*DATA_W-1:0] rdata_o,
   output logic [NUM_RD-1:0]        rbusy_o,
   input  logic                     iss_i,
   input  logic [ADDR_W-1:0]        iss_rd_i,
   output logic [2**ADDR_W-1:0]     busy_o
);

   localparam int DEPTH = 2**ADDR_W;

   logic [ADDR_W-1:0] waddr   [NUM_WR];
   logic [DATA_W-1:0] wdata   [NUM_WR];
   logic              wvalid  [NUM_WR];
   logic [ADDR_W-1:0] raddr   [NUM_RD];
   logic [DATA_W-1:0] rd_data [NUM_RD];
   logic              rd_busy [NUM_RD];
   logic              fwd_hit [NUM_RD];
   logic [DATA_W-1:0] fwd_data[NUM_RD];

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   // A write to x0 is dropped here, so x0 can neither be stored nor forwarded.
   for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
      assign waddr[k]  = waddr_i[k*ADDR_W +: ADDR_W];
      assign wdata[k]  = wdata_i[k*DATA_W +: DATA_W];
      assign wvalid[k] = we_i[k] && (waddr[k] != '0);
   end

   for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      assign raddr[j]                    = raddr_i[j*ADDR_W +: ADDR_W];
      assign rdata_o[j*DATA_W +: DATA_W] = rd_data[j];
      assign rbusy_o[j]                  = rd_busy[j];
   end

   // Writes clear busy bits before issue sets them, so a new producer beats a retiring one.
   always_comb begin
      busy_d = busy_q;
      for (int k = 0; k < NUM_WR; k++) begin
         if (wvalid[k]) begin
            busy_d[waddr[k]] = 1'b0;
         end
      end
      if (iss_i && (iss_rd_i != '0)) begin
         busy_d[iss_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Ports are applied in ascending order, so the last non-blocking write comes from the highest index and wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         busy_q <= busy_d;
         for (int k = 0; k < NUM_WR; k++) begin
            if (wvalid[k]) begin
               regs[waddr[k]] <= wdata[k];
            end
         end
      end
   end

   // A forwarded value is complete, so the port does not report busy for it.
   always_comb begin
      for (int j = 0; j < NUM_RD; j++) begin
         fwd_hit[j]  = 1'b0;
         fwd_data[j] = '0;
         for (int k = 0; k < NUM_WR; k++) begin
            if (wvalid[k] && (waddr[k] == raddr[j])) begin
               fwd_hit[j]  = 1'b1;
               fwd_data[j] = wdata[k];
            end
         end
         rd_data[j] = '0;
         rd_busy[j] = 1'b0;
         if (!rst && re_i[j] && (raddr[j] != '0)) begin
            if ((BYPASS != 0) && fwd_hit[j]) begin
               rd_data[j] = fwd_data[j];
            end else begin
               rd_data[j] = regs[raddr[j]];
               rd_busy[j] = busy_q[raddr[j]];
            end
         end
      end
   end

   assign busy_o = busy_q;

endmodule
